// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef logic [AW-1:0] reg_addr_t;

  // One writeback request as seen at the shared write port.
  typedef struct packed {
    reg_addr_t         addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/rf_arb_grant.sv
// Grant selection for the shared write port.
// Build option RF_ARB_RR_EN: when defined, round-robin with a rotating start
// pointer; otherwise fixed priority, lowest index wins, and no state is kept.
module rf_arb_grant
  import rf_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
`ifdef RF_ARB_RR_EN
  input  logic            clk,
  input  logic            reset,
`endif
  input  logic [NREQ-1:0] req_valid_i,
  input  logic            stall_i,
  output logic [NREQ-1:0] grant_o
);

  logic found;

`ifdef RF_ARB_RR_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic [PW-1:0] gidx;

  // Search starting at the pointer; after a grant the pointer moves past the winner.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    gidx    = ptr_q;
    if (!stall_i) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = PW'((int'(ptr_q) + k) % NREQ);
        if (!found && req_valid_i[idx]) begin
          grant_o[idx] = 1'b1;
          found        = 1'b1;
          gidx         = idx;
        end
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (int'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: the lowest-indexed valid requester wins.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    if (!stall_i) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req_valid_i[k]) begin
          grant_o[k] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port (WE3/A3/WD3) between NREQ writeback
// sources and keeps a per-register busy scoreboard for decode hazard checks.
// Build option RF_ARB_RR_EN selects round-robin instead of fixed priority.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = rf_arb_pkg::XLEN,
  parameter int AW   = rf_arb_pkg::AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 wb_stall,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  input  logic                 flush,
  input  logic [AW-1:0]        chk_a1,
  input  logic [AW-1:0]        chk_a2,
  output logic                 chk_busy1,
  output logic                 chk_busy2,
  output logic                 WE3,
  output logic [AW-1:0]        A3,
  output logic [XLEN-1:0]      WD3,
  output logic                 err
);

  localparam int NREG = 1 << AW;

  logic [NREQ-1:0] grant;
  logic            accept;
  logic            wr_en;
  logic            rsv_hit;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;

  logic            we3_q, we3_d;
  logic [AW-1:0]   a3_q, a3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;

  rf_arb_grant #(.NREQ(NREQ)) u_grant (
`ifdef RF_ARB_RR_EN
    .clk         (clk),
    .reset       (reset),
`endif
    .req_valid_i (req_valid),
    .stall_i     (wb_stall),
    .grant_o     (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  // x0 writes complete the handshake but never reach the register file.
  assign wr_en     = accept && (sel_addr != '0);
  assign rsv_hit   = rsv_valid && !flush && (rsv_addr != '0);

  // Steer the granted requester's address and data (grant is one-hot or zero).
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | req_addr[i*AW +: AW];
        sel_data = sel_data | req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Next state for the write port, scoreboard and sticky error flag.
  always_comb begin
    we3_d  = wr_en;
    a3_d   = accept ? sel_addr : a3_q;
    wd3_d  = accept ? sel_data : wd3_q;
    busy_d = busy_q;
    err_d  = err_q;
    if (wr_en) begin
      busy_d[sel_addr] = 1'b0;
    end
    // Reserve is applied after the clear so it wins on the same register.
    if (rsv_hit) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    // A write pairs with a same-cycle reservation of its target, so that is not an error.
    if (wr_en && !busy_q[sel_addr] && !(rsv_hit && (rsv_addr == sel_addr))) begin
      err_d = 1'b1;
    end
    // Re-reserving a register is fine when its outstanding write retires this cycle.
    if (rsv_hit && busy_q[rsv_addr] && !(wr_en && (sel_addr == rsv_addr))) begin
      err_d = 1'b1;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we3_q  <= 1'b0;
      a3_q   <= '0;
      wd3_q  <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      we3_q  <= we3_d;
      a3_q   <= a3_d;
      wd3_q  <= wd3_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign WE3       = we3_q;
  assign A3        = a3_q;
  assign WD3       = wd3_q;
  assign err       = err_q;
  assign chk_busy1 = (chk_a1 != '0) && busy_q[chk_a1];
  assign chk_busy2 = (chk_a2 != '0) && busy_q[chk_a2];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (NREQ=2, XLEN=32, AW=5).
module tb_rf_write_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic        wb_stall;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        flush;
  logic [4:0]  chk_a1;
  logic [4:0]  chk_a2;
  logic        chk_busy1;
  logic        chk_busy2;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        err;

  int vectors;
  int miscompares;

  rf_write_arbiter #(.NREQ(2), .XLEN(32), .AW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wb_stall  (wb_stall),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .flush     (flush),
    .chk_a1    (chk_a1),
    .chk_a2    (chk_a2),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Short asynchronous reset pulse between clock edges.
  task automatic pulse_reset();
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    logic [4:0] exp_a;
    vectors     = 0;
    miscompares = 0;
    reset     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    wb_stall  = 1'b0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    flush     = 1'b0;
    chk_a1    = 5'd7;
    chk_a2    = 5'd0;
    #2;
    check("rst_we3", 64'(WE3), 64'(1'b0));
    check("rst_a3", 64'(A3), 64'(5'd0));
    check("rst_wd3", 64'(WD3), 64'(32'h0));
    check("rst_err", 64'(err), 64'(1'b0));
    check("rst_busy", 64'(chk_busy1), 64'(1'b0));
    check("rst_ready", 64'(req_ready), 64'(2'b00));
    #1 reset = 1'b1;

    // 1: single write from requester 0
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd5};
    req_data  = {32'h0, 32'hDEADBEEF};
    #1 check("t1_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    check("t1_we3", 64'(WE3), 64'(1'b1));
    check("t1_a3", 64'(A3), 64'(5'd5));
    check("t1_wd3", 64'(WD3), 64'(32'hDEADBEEF));
    check("t1_err_nonbusy", 64'(err), 64'(1'b1));
    tick();
    check("t1_we3_off", 64'(WE3), 64'(1'b0));
    check("t1_a3_hold", 64'(A3), 64'(5'd5));
    check("t1_wd3_hold", 64'(WD3), 64'(32'hDEADBEEF));
    pulse_reset();
    check("t1_err_cleared", 64'(err), 64'(1'b0));

    // 2: reserve x7, then requester 1 retires it
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    tick();
    rsv_valid = 1'b0;
    chk_a1    = 5'd7;
    #1 check("t2_busy_set", 64'(chk_busy1), 64'(1'b1));
    check("t2_busy2_x0", 64'(chk_busy2), 64'(1'b0));
    req_valid = 2'b10;
    req_addr  = {5'd7, 5'd0};
    req_data  = {32'h0000_0077, 32'h0};
    #1 check("t2_ready", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid = 2'b00;
    check("t2_busy_clr", 64'(chk_busy1), 64'(1'b0));
    check("t2_we3", 64'(WE3), 64'(1'b1));
    check("t2_a3", 64'(A3), 64'(5'd7));
    check("t2_wd3", 64'(WD3), 64'(32'h0000_0077));
    check("t2_err", 64'(err), 64'(1'b0));

    // 4: write to x0
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd0};
    req_data  = {32'h0, 32'h0000_1234};
    #1 check("t4_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    check("t4_we3", 64'(WE3), 64'(1'b0));
    check("t4_err", 64'(err), 64'(1'b0));

    // 5: reserve and retire x3 in one cycle, then reserve again
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd3};
    req_data  = {32'h0, 32'h0000_0033};
    rsv_valid = 1'b1;
    rsv_addr  = 5'd3;
    #1 check("t5_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    chk_a1    = 5'd3;
    #1 check("t5_busy", 64'(chk_busy1), 64'(1'b1));
    check("t5_err0", 64'(err), 64'(1'b0));
    check("t5_a3", 64'(A3), 64'(5'd3));
    tick();
    rsv_valid = 1'b0;
    check("t5_err1", 64'(err), 64'(1'b1));

    // 3: both requesters valid for four cycles
    pulse_reset();
    req_valid = 2'b11;
    req_addr  = {5'd11, 5'd10};
    req_data  = {32'hBBBB_0001, 32'hAAAA_0000};
    for (int i = 0; i < 4; i++) begin
`ifdef RF_ARB_RR_EN
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      exp_a = exp_g[1] ? 5'd11 : 5'd10;
      #1 check($sformatf("t3_grant%0d", i), 64'(req_ready), 64'(exp_g));
      tick();
      check($sformatf("t3_a3_%0d", i), 64'(A3), 64'(exp_a));
    end
    req_valid = 2'b00;

    // 6: stall handling and asynchronous reset mid-stream
    pulse_reset();
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd4};
    req_data  = {32'h0, 32'h0000_0044};
    wb_stall  = 1'b1;
    #1 check("t6_stall_ready", 64'(req_ready), 64'(2'b00));
    tick();
    check("t6_stall_we3", 64'(WE3), 64'(1'b0));
    wb_stall = 1'b0;
    #1 check("t6_go_ready", 64'(req_ready), 64'(2'b01));
    tick();
    wb_stall = 1'b1;
    #1 check("t6_mid_ready", 64'(req_ready), 64'(2'b00));
    check("t6_mid_we3", 64'(WE3), 64'(1'b1));
    tick();
    check("t6_after_we3", 64'(WE3), 64'(1'b0));
    req_valid = 2'b00;
    wb_stall  = 1'b0;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    tick();
    rsv_valid = 1'b0;
    chk_a1    = 5'd9;
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd4};
    #1 check("t6_busy9", 64'(chk_busy1), 64'(1'b1));
    tick();
    req_valid = 2'b00;
    check("t6_pre_we3", 64'(WE3), 64'(1'b1));
    #1 reset = 1'b0;
    #1 check("t6_arst_we3", 64'(WE3), 64'(1'b0));
    check("t6_arst_busy", 64'(chk_busy1), 64'(1'b0));
    reset = 1'b1;

    // flush drops a simultaneous reserve but not an accepted write
    rsv_valid = 1'b1;
    rsv_addr  = 5'd12;
    tick();
    chk_a1 = 5'd12;
    chk_a2 = 5'd13;
    #1 check("fl_busy12", 64'(chk_busy1), 64'(1'b1));
    flush     = 1'b1;
    rsv_addr  = 5'd13;
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd20};
    req_data  = {32'h0, 32'h0000_2020};
    tick();
    flush     = 1'b0;
    rsv_valid = 1'b0;
    req_valid = 2'b00;
    check("fl_busy12_clr", 64'(chk_busy1), 64'(1'b0));
    check("fl_busy13_drop", 64'(chk_busy2), 64'(1'b0));
    check("fl_we3", 64'(WE3), 64'(1'b1));
    check("fl_a3", 64'(A3), 64'(5'd20));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
